// File: rtl/uart_tx_scheduler_if.sv
// Requester bus and serial-line outputs of uart_tx_scheduler.
// master = requester side, slave = the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  tx,
    input  busy,
    input  grant_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output tx,
    output busy,
    output grant_id
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmitter shared by NUM_REQ byte producers.
// Define UART_TX_PARITY_EN to append an even-parity bit to each frame.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 100,
  parameter int ID_W         = 2
) (
  input logic                clk,
  input logic                rst_n,
  uart_tx_scheduler_if.slave bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BW-1:0]      baud_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    gid_q;
  logic               busy_q;
  logic               tick;
  logic               last_bit;
  logic               found;
  logic               grant;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    ptr_nxt;
  logic [7:0]         data_sel;
  logic [NUM_REQ-1:0] ready;
  logic               tx;

`ifdef UART_TX_PARITY_EN
  logic par_q;
`endif

  assign tick     = baud_q == BW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_q == 3'd7;
  assign grant    = (state_q == IDLE) && found;

  // Lowest valid index overall, then overridden by the
  // lowest valid index at or above the pointer if one exists.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (ID_W'(i) >= ptr_q)) begin
        win = ID_W'(i);
      end
    end
  end

  always_comb begin
    data_sel = '0;
    ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        data_sel = bus.req_data[8*i +: 8];
        ready[i] = grant;
      end
    end
  end

  assign ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ?
                   '0 : win + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (found) state_d = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
`ifdef UART_TX_PARITY_EN
        if (tick && last_bit) state_d = PARITY;
`else
        if (tick && last_bit) state_d = STOP;
`endif
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      baud_q <= '0;
      bit_q  <= '0;
      if (found) begin
        shift_q <= data_sel;
        gid_q   <= win;
        ptr_q   <= ptr_nxt;
        busy_q  <= 1'b1;
      end
    end else begin
      baud_q <= tick ? '0 : baud_q + BW'(1);
      if (tick && state_q == DATA) begin
        shift_q <= shift_q >> 1;
        bit_q   <= bit_q + 3'd1;
      end
      if (tick && state_q == STOP) begin
        busy_q <= 1'b0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (grant) begin
      par_q <= ^data_sel;
    end
  end
`endif

  // Decoded from state so an async reset idles the line at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = par_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign bus.tx        = tx;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gid_q;
  assign bus.req_ready = ready;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table,
// corner-case sequences and a randomized run against a frame model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int IDW = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_scheduler_if #(.NUM_REQ(N), .ID_W(IDW)) bus();

  uart_tx_scheduler #(
    .NUM_REQ(N),
    .CLKS_PER_BIT(CPB),
    .ID_W(IDW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Line bits in transmit order, index 0 = start bit.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic [N-1:0]   exp_ready;
    logic [IDW-1:0] exp_gid;
    logic [7:0]     exp_byte;
  } vec_t;

  vec_t tbl[7];

  task automatic run_vec(input vec_t v);
    logic [FL-1:0] w;
    logic [NB-1:0] fb;
    @(negedge clk);
    bus.req_valid = v.valid;
    bus.req_data  = v.data;
    #1;
    chk("vec ready", bus.req_ready, v.exp_ready);
    chk("vec idle busy", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    chk("vec grant_id", bus.grant_id, v.exp_gid);
    for (int c = 0; c < FL; c++) begin
      w[c] = bus.tx;
      chk("vec frame busy", bus.busy, 1);
      chk("vec frame ready", bus.req_ready, 0);
      @(posedge clk);
      #1;
    end
    chk("vec end busy", bus.busy, 0);
    chk("vec end tx", bus.tx, 1);
    fb = frame_bits(v.exp_byte);
    for (int b = 0; b < NB; b++) begin
      chk("vec line bit", w[b*CPB +: CPB], {CPB{fb[b]}});
    end
  endtask

  logic [N-1:0] v;
  logic [7:0]   d [N];
  int m_ptr, m_gid, m_t, w, n, c0, last;
  bit m_act;
  logic [NB-1:0] m_bits;
  logic [N-1:0] er;
  logic etx, eb;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    #2;
    chk("reset tx", bus.tx, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset ready", bus.req_ready, 0);
    chk("reset grant_id", bus.grant_id, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle tx", bus.tx, 1);
      chk("idle ready", bus.req_ready, 0);
      chk("idle busy", bus.busy, 0);
    end

    tbl[0] = '{4'b0001, 32'h0000001E, 4'b0001, 2'd0, 8'h1E};
    tbl[1] = '{4'b0101, 32'h00C30055, 4'b0100, 2'd2, 8'hC3};
    tbl[2] = '{4'b1001, 32'hFF000000, 4'b1000, 2'd3, 8'hFF};
    tbl[3] = '{4'b1110, 32'h5A7E8100, 4'b0010, 2'd1, 8'h81};
    tbl[4] = '{4'b0011, 32'h00003CA5, 4'b0001, 2'd0, 8'hA5};
    tbl[5] = '{4'b0010, 32'h00000100, 4'b0010, 2'd1, 8'h01};
    tbl[6] = '{4'b0001, 32'h0000001F, 4'b0001, 2'd0, 8'h1F};
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Back-to-back: all requesters held valid.
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'hA3A2A1A0;
    #1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (bus.req_ready == '0 && n < 2 * FL + 4) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("b2b onehot", $onehot(bus.req_ready), 1);
      chk("b2b ready", bus.req_ready, 4'b0001 << (k % N));
      if (k > 0) chk("b2b spacing", cyc - last, FL + 1);
      last = cyc;
      @(posedge clk);
      #1;
      chk("b2b grant_id", bus.grant_id, k % N);
    end
    bus.req_valid = '0;

    // Late request raised during a frame.
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000003C;
    #1;
    chk("late first ready", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.req_valid = '0;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00990000;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 2 * FL) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("late ready", bus.req_ready, 4'b0100);
    chk("late wait", cyc - c0, FL);
    chk("late busy", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    chk("late grant_id", bus.grant_id, 2);

    // Reset in the middle of the first data bit.
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h00005A00;
    #1;
    chk("rst pre ready", bus.req_ready, 4'b0010);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (CPB + 1) @(posedge clk);
    #2;
    chk("rst pre tx", bus.tx, 0);
    chk("rst pre busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst async tx", bus.tx, 1);
    chk("rst async busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst ptr ready", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    chk("rst ptr grant_id", bus.grant_id, 0);

    // Randomized traffic against the frame-level model.
    do_reset();
    v = '0;
    for (int i = 0; i < N; i++) d[i] = '0;
    m_ptr = 0;
    m_gid = 0;
    m_t = 0;
    m_act = 0;
    m_bits = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          if ($urandom_range(63) == 0) v[i] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          v[i] = 1'b1;
          d[i] = 8'($urandom);
        end
      end
      bus.req_valid = v;
      for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = d[i];
      #1;
      w = -1;
      er = '0;
      if (m_act) begin
        etx = m_bits[m_t / CPB];
        eb = 1'b1;
      end else begin
        etx = 1'b1;
        eb = 1'b0;
        w = rr_pick(v, m_ptr);
        if (w >= 0) er[w] = 1'b1;
      end
      chk("rand tx", bus.tx, etx);
      chk("rand busy", bus.busy, eb);
      chk("rand ready", bus.req_ready, er);
      chk("rand grant_id", bus.grant_id, m_gid);
      if (m_act) begin
        m_t++;
        if (m_t == FL) m_act = 0;
      end else if (w >= 0) begin
        m_act = 1;
        m_t = 0;
        m_gid = w;
        m_ptr = (w + 1) % N;
        m_bits = frame_bits(d[w]);
        v[w] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
